// File: rtl/puf_arbiter_pkg.sv
// Shared definitions for the PUF arbiter: FSM encoding and default timing constants.
package puf_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENG_RST = 2'd1,
        ST_RUN     = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic [15:0] TIMEOUT_DEF     = 16'd1023;
    localparam int          ENG_RST_CYC_DEF = 2;
    localparam logic [7:0]  ERR_CNT_MAX     = 8'd255;

endpackage

// File: rtl/puf_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr+1, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [2:0]       gnt_o,
    output logic             any_o
);

    logic found;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        gnt_o = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req_i[j] && (j == ((int'(ptr_i) + k) % N_REQ))) begin
                    gnt_o = 3'(j);
                    found = 1'b1;
                end
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/puf_arbiter.sv
// Arbitrates N_REQ requesters onto one shared PUF engine: reset, run with timeout, respond.
module puf_arbiter
    import puf_arbiter_pkg::*;
#(
    parameter int          N_REQ       = 4,
    parameter logic [15:0] TIMEOUT     = TIMEOUT_DEF,
    parameter int          ENG_RST_CYC = ENG_RST_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  chal_in,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [127:0]         resp_data,
    output logic                 resp_err,
    output logic [2:0]           gnt_id,
    output logic                 busy,
    output logic                 eng_rst,
    output logic [15:0]          eng_chal,
    input  logic [127:0]         eng_resp,
    input  logic                 eng_done,
    output logic [7:0]           err_cnt
);

    localparam int RC_W = (ENG_RST_CYC > 1) ? $clog2(ENG_RST_CYC) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(ENG_RST_CYC - 1);

    state_e          state_q, state_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [15:0]     chal_q, chal_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [15:0]     run_cnt_q, run_cnt_d;
    logic [127:0]    data_q, data_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [2:0]      pick;
    logic            any_req;
    logic [15:0]     chal_sel;
    logic            accept;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick),
        .any_o (any_req)
    );

    always_comb begin
        chal_sel = 16'd0;
        for (int j = 0; j < N_REQ; j++) begin
            if (pick == 3'(j)) chal_sel = chal_in[16*j +: 16];
        end
    end

    assign resp_valid = (state_q == ST_RESP) ? (N_REQ'(1) << gnt_q) : '0;
    // Only the granted lane's ready can complete the handshake.
    assign accept     = |(resp_ready & resp_valid);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        chal_d    = chal_q;
        rc_d      = rc_q;
        run_cnt_d = run_cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    chal_d  = chal_sel;
                    rc_d    = '0;
                    state_d = ST_ENG_RST;
                end
            end
            ST_ENG_RST: begin
                if (rc_q == RC_LAST) begin
                    run_cnt_d = 16'd0;
                    state_d   = ST_RUN;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (eng_done) begin
                    data_d  = eng_resp;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (run_cnt_q == TIMEOUT) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
                    state_d = ST_RESP;
                end else begin
                    run_cnt_d = run_cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (accept) begin
                    ptr_d   = gnt_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 3'd0;
            ptr_q     <= 3'(N_REQ - 1);
            chal_q    <= 16'd0;
            rc_q      <= '0;
            run_cnt_q <= 16'd0;
            data_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            chal_q    <= chal_d;
            rc_q      <= rc_d;
            run_cnt_q <= run_cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign eng_rst   = (state_q == ST_IDLE) || (state_q == ST_ENG_RST);
    assign gnt_id    = gnt_q;
    assign eng_chal  = chal_q;
    assign resp_data = data_q;
    assign resp_err  = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_puf_arbiter.sv
// Directed bench for puf_arbiter with a behavioural engine stub and a small-TIMEOUT second instance.
module tb_puf_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req = '0;
    logic [16*N-1:0]  chal_in = '0;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready = '0;
    logic [127:0]     resp_data;
    logic             resp_err;
    logic [2:0]       gnt_id;
    logic             busy;
    logic             eng_rst;
    logic [15:0]      eng_chal;
    logic [127:0]     eng_resp = '0;
    logic             eng_done;
    logic [7:0]       err_cnt;

    logic [1:0]       req_s = '0;
    logic [31:0]      chal_in_s = 32'hFACE_B00C;
    logic [1:0]       resp_valid_s;
    logic [1:0]       resp_ready_s = '1;
    logic [127:0]     resp_data_s;
    logic             resp_err_s;
    logic [2:0]       gnt_id_s;
    logic             busy_s;
    logic             eng_rst_s;
    logic [15:0]      eng_chal_s;
    logic [7:0]       err_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    int eng_cyc    = 0;
    int done_after = 40;
    bit done_en    = 1'b1;

    always #5 clk = ~clk;

    // Engine stub: done goes high done_after cycles after reset is released and stays high.
    always @(posedge clk) eng_cyc <= eng_rst ? 0 : eng_cyc + 1;
    assign eng_done = done_en && !eng_rst && (eng_cyc >= done_after);

    puf_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .chal_in    (chal_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .eng_rst    (eng_rst),
        .eng_chal   (eng_chal),
        .eng_resp   (eng_resp),
        .eng_done   (eng_done),
        .err_cnt    (err_cnt)
    );

    puf_arbiter #(.N_REQ(2), .TIMEOUT(16'd8)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .req        (req_s),
        .chal_in    (chal_in_s),
        .resp_valid (resp_valid_s),
        .resp_ready (resp_ready_s),
        .resp_data  (resp_data_s),
        .resp_err   (resp_err_s),
        .gnt_id     (gnt_id_s),
        .busy       (busy_s),
        .eng_rst    (eng_rst_s),
        .eng_chal   (eng_chal_s),
        .eng_resp   (128'hDEAD_BEEF),
        .eng_done   (1'b0),
        .err_cnt    (err_cnt_s)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge with the DUT idle and req already applied.
    task automatic serve(input string tag, input int exp_gnt, input logic [15:0] exp_chal,
                         input logic exp_err, input logic [127:0] exp_data,
                         input int exp_lat, input logic [7:0] exp_err_cnt);
        int lat    = 0;
        int rst_hi = 0;
        bit seen   = 1'b0;
        for (int c = 1; c <= 3000 && !seen; c++) begin
            @(negedge clk);
            if (busy && eng_rst) rst_hi++;
            if (resp_valid != '0) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, " resp_valid seen"}, 128'(seen), 128'd1);
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " eng_rst cycles"}, 128'(rst_hi), 128'd2);
        check({tag, " resp_valid"}, 128'(resp_valid), 128'(N'(1) << exp_gnt));
        check({tag, " gnt_id"}, 128'(gnt_id), 128'(exp_gnt));
        check({tag, " eng_chal"}, 128'(eng_chal), 128'(exp_chal));
        check({tag, " resp_err"}, 128'(resp_err), 128'(exp_err));
        check({tag, " resp_data"}, resp_data, exp_data);
        check({tag, " err_cnt"}, 128'(err_cnt), 128'(exp_err_cnt));
    endtask

    task automatic accept(input string tag, input int g);
        resp_ready = N'(1) << g;
        @(negedge clk);
        resp_ready = '0;
        check({tag, " idle after accept"}, 128'(busy), 128'd0);
        check({tag, " valid dropped"}, 128'(resp_valid), 128'd0);
        check({tag, " engine parked"}, 128'(eng_rst), 128'd1);
    endtask

    initial begin
        logic [127:0] word;
        int bad_data, bad_valid, bad_gnt, stray, i_seen;
        bit got;

        repeat (3) @(negedge clk);
        check("rst resp_valid", 128'(resp_valid), 128'd0);
        check("rst busy", 128'(busy), 128'd0);
        check("rst eng_rst", 128'(eng_rst), 128'd1);
        check("rst gnt_id", 128'(gnt_id), 128'd0);
        check("rst eng_chal", 128'(eng_chal), 128'd0);
        check("rst err_cnt", 128'(err_cnt), 128'd0);
        check("rst resp_err", 128'(resp_err), 128'd0);
        check("rst resp_data", resp_data, 128'd0);
        rst = 1'b1;

        // Single requester, engine done 40 cycles after reset release.
        done_after = 40;
        eng_resp   = {16{8'hA5}};
        chal_in    = {16'h0, 16'h0, 16'h0, 16'h1234};
        req        = 4'b0001;
        serve("single", 0, 16'h1234, 1'b0, {16{8'hA5}}, 44, 8'd0);
        req = '0;
        accept("single", 0);

        // All four requesting: round-robin from index 0 after reset.
        do_reset();
        done_after = 3;
        chal_in    = {16'hC0D3, 16'hC0D2, 16'hC0D1, 16'hC0D0};
        req        = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            word     = {8{16'hBEE0 + 16'(s)}};
            eng_resp = word;
            serve($sformatf("rr%0d", s), s % 4, 16'hC0D0 + 16'(s % 4), 1'b0, word, 7, 8'd0);
            accept($sformatf("rr%0d", s), s % 4);
        end
        req = '0;

        // Engine never finishes: timeout clears the previous data and bumps err_cnt.
        done_en = 1'b0;
        chal_in = {16'h0, 16'h2A2A, 16'h0, 16'h0};
        req     = 4'b0100;
        serve("timeout", 2, 16'h2A2A, 1'b1, 128'd0, 1027, 8'd1);
        req = '0;
        accept("timeout", 2);

        // Done arrives on the timeout cycle; then a long RESP stall with stray readies.
        done_en    = 1'b1;
        done_after = 1023;
        word       = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        eng_resp   = word;
        chal_in    = {16'h0, 16'h0, 16'h5151, 16'h0};
        req        = 4'b0010;
        serve("coincide", 1, 16'h5151, 1'b0, word, 1027, 8'd1);
        req = '0;
        bad_data  = 0;
        bad_valid = 0;
        bad_gnt   = 0;
        for (int c = 0; c < 20; c++) begin
            resp_ready = (c >= 5 && c < 8) ? 4'b1101 : 4'b0000;
            @(negedge clk);
            if (resp_data !== word) bad_data++;
            if (resp_valid !== 4'b0010) bad_valid++;
            if (gnt_id !== 3'd1) bad_gnt++;
        end
        resp_ready = '0;
        check("stall data stable", 128'(bad_data), 128'd0);
        check("stall valid stable", 128'(bad_valid), 128'd0);
        check("stall gnt stable", 128'(bad_gnt), 128'd0);
        accept("coincide", 1);

        // Reset asserted mid-RUN takes effect without a clock edge.
        done_after = 40;
        chal_in    = {16'h0, 16'h0, 16'h0, 16'h9999};
        req        = 4'b0001;
        repeat (10) @(negedge clk);
        check("mid run busy", 128'(busy), 128'd1);
        check("mid run eng_rst", 128'(eng_rst), 128'd0);
        #2 rst = 1'b0;
        #1;
        check("async busy", 128'(busy), 128'd0);
        check("async eng_rst", 128'(eng_rst), 128'd1);
        check("async gnt_id", 128'(gnt_id), 128'd0);
        check("async eng_chal", 128'(eng_chal), 128'd0);
        check("async err_cnt", 128'(err_cnt), 128'd0);
        check("async resp_data", resp_data, 128'd0);
        check("async resp_err", 128'(resp_err), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        stray = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (resp_valid != '0 || busy) stray++;
        end
        check("no response after reset", 128'(stray), 128'd0);
        word     = {4{32'h7777_0001}};
        eng_resp = word;
        chal_in  = {16'h7777, 16'h0, 16'h0, 16'h0};
        req      = 4'b1000;
        serve("post reset", 3, 16'h7777, 1'b0, word, 44, 8'd0);
        req = '0;
        accept("post reset", 3);

        // Saturating error counter on the short-timeout instance.
        req_s  = 2'b11;
        i_seen = 0;
        for (int i = 1; i <= 260; i++) begin
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                if (resp_valid_s != '0) got = 1'b1;
            end
            if (!got) break;
            i_seen = i;
            if (i == 1 || i == 255 || i == 256 || i == 260)
                check($sformatf("sat err_cnt %0d", i), 128'(err_cnt_s), 128'((i > 255) ? 255 : i));
            @(negedge clk);
        end
        check("sat services", 128'(i_seen), 128'd260);
        check("sat resp_err", 128'(resp_err_s), 128'd1);
        check("sat resp_data", resp_data_s, 128'd0);
        req_s = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_arbiter.md
PUF_ARBITER -- requirements
Module: puf_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16'd1023, maximum engine cycles per run before abort.
REQ-003 SHALL have parameter ENG_RST_CYC, default 2, engine-reset hold cycles (>=1).
REQ-004 clk  input  1  sole clock, all flops rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester level request, held until its response is accepted.
REQ-007 chal_in  input  16*N_REQ  per-requester challenge, slice i = chal_in[16i+15:16i].
REQ-008 resp_valid  output  N_REQ  one-hot response-valid to the granted requester.
REQ-009 resp_ready  input  N_REQ  per-requester response acceptance.
REQ-010 resp_data  output  128  shared response bus, meaningful only while resp_valid != 0.
REQ-011 resp_err  output  1  qualifies resp_data: 1 = engine timed out, data zeroed.
REQ-012 gnt_id  output  3  index of the requester currently in service.
REQ-013 busy  output  1  high whenever FSM is not IDLE.
REQ-014 eng_rst  output  1  active-high synchronous reset to the shared 128-bit PUF engine.
REQ-015 eng_chal  output  16  challenge driven to the engine.
REQ-016 eng_resp  input  128  engine response word.
REQ-017 eng_done  input  1  engine completion, sticky high until engine reset.
REQ-018 err_cnt  output  8  saturating count of timeouts.

Function
REQ-019 SHALL implement FSM states IDLE, ENG_RST, RUN, RESP, with no other reachable state.
REQ-020 IDLE: when req != 0, SHALL grant round-robin starting at index ptr+1 (wrapping at N_REQ), latch gnt_id and eng_chal from that slice, and enter ENG_RST next cycle.
REQ-021 ENG_RST: SHALL hold eng_rst=1 for exactly ENG_RST_CYC cycles, then enter RUN with eng_rst=0.
REQ-022 eng_chal SHALL stay constant from grant until the FSM returns to IDLE.
REQ-023 RUN: SHALL count cycles from 0; when eng_done=1, SHALL latch eng_resp into resp_data, clear resp_err, and enter RESP.
REQ-024 RUN: when the count reaches TIMEOUT with eng_done=0, SHALL set resp_data=0 and resp_err=1, increment err_cnt (saturating at 255), and enter RESP.
REQ-025 If eng_done and timeout coincide, eng_done SHALL win (no error).
REQ-026 RESP: SHALL drive resp_valid[gnt_id]=1, others 0, with resp_data/resp_err stable until resp_ready[gnt_id]=1.
REQ-027 On acceptance, SHALL set ptr=gnt_id, set eng_rst=1 (engine parked in reset), and return to IDLE next cycle.
REQ-028 resp_ready on non-granted indices SHALL be ignored.
REQ-029 A req deasserted after grant SHALL NOT abort service; the response is still presented.
REQ-030 eng_rst SHALL be 1 in IDLE; eng_done SHALL be ignored outside RUN.
REQ-031 A new grant SHALL occur no earlier than the cycle after acceptance (minimum one IDLE cycle between services).
REQ-032 Latency SHALL be 1 + ENG_RST_CYC + engine run cycles + 1 from request to resp_valid.

Reset
REQ-033 On rst=0, all state SHALL clear asynchronously: FSM=IDLE, ptr=N_REQ-1, gnt_id=0, resp_valid=0, resp_data=0, resp_err=0, busy=0, eng_rst=1, eng_chal=0, err_cnt=0, run counter=0.
REQ-034 Reset mid-service SHALL discard the in-flight request without emitting resp_valid.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the default TIMEOUT and ENG_RST_CYC constants.
REQ-036 The round-robin priority picker SHALL be one sub-module, rr_pick, taking req and ptr and returning a grant index and an any-request flag.

Verification
REQ-037 Single req[0], chal 16'h1234, engine stub asserts eng_done 40 cycles after eng_rst falls with 128'hA5..A5 -> resp_valid=4'b0001 with that data, resp_err=0, eng_rst high for exactly 2 cycles.
REQ-038 req=4'b1111 held continuously -> grant order 0,1,2,3,0, and each eng_chal equals its slice.
REQ-039 Engine stub never asserts eng_done -> after 1023 RUN cycles resp_err=1, resp_data=0, err_cnt=1; 256 repeats -> err_cnt stays 255.
REQ-040 resp_ready held low 20 cycles during RESP -> resp_data, resp_valid, and gnt_id stable; resp_ready[2] pulses while gnt_id=1 -> ignored.
REQ-041 rst pulsed low during RUN -> all outputs take reset values immediately, no resp_valid afterwards, and the next req is serviced normally.
REQ-042 eng_done rises on the same cycle the count hits TIMEOUT -> resp_err=0 and eng_resp is delivered.
